// File: rtl/operand_fetch_if.sv
// Decoded-instruction, write-back and ALU-operand bus of the operand fetch stage.
// slave is the fetch stage's view; master is the surrounding pipeline's view.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [15:0]       imm;
  logic              alu_src;
  logic [3:0]        alu_op;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic [3:0]        op;
  logic              illegal_op;

  modport slave (
    input  in_valid, rs, rt, imm, alu_src, alu_op,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid, X, Y, op, illegal_op
  );

  modport master (
    output in_valid, rs, rt, imm, alu_src, alu_op,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid, X, Y, op, illegal_op
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file with write-back bypass, immediate select,
// and a single registered output slot with valid/ready flow control.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.slave  bus
);
  localparam int unsigned NREGS     = 1 << ADDR_W;
  localparam logic [15:0] LEGAL_OPS = 16'h90C7; // ops 0,1,2,6,7,12,15

  logic [DATA_W-1:0] regs [NREGS];

  logic              out_valid_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [3:0]        op_q;
  logic              illegal_q;

  logic              accept;
  logic              wb_live;
  logic [DATA_W-1:0] x_next;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] y_next;

  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.X          = x_q;
  assign bus.Y          = y_q;
  assign bus.op         = op_q;
  assign bus.illegal_op = illegal_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign wb_live = bus.wb_en && (bus.wb_addr != '0);

  // Bypass the same-cycle write so the operand never sees a stale register.
  always_comb begin
    x_next = '0;
    if (wb_live && (bus.wb_addr == bus.rs))
      x_next = bus.wb_data;
    else if (bus.rs != '0)
      x_next = regs[bus.rs];
  end

  always_comb begin
    rt_val = '0;
    if (wb_live && (bus.wb_addr == bus.rt))
      rt_val = bus.wb_data;
    else if (bus.rt != '0)
      rt_val = regs[bus.rt];
  end

  always_comb begin
    y_next = rt_val;
    if (bus.alu_src)
      y_next = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_live) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (accept) begin
        x_q  <= x_next;
        y_q  <= y_next;
        op_q <= bus.alu_op;
        if (!LEGAL_OPS[bus.alu_op])
          illegal_q <= 1'b1;
      end
      if (accept)
        out_valid_q <= 1'b1;
      else if (bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  operand_fetch_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.imm       = '0;
    bus.alu_src   = 1'b0;
    bus.alu_op    = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.X !== 32'h0) begin n_fail++; $display("FAIL reset_X got %h want 0", bus.X); end
    n_checks++; if (bus.Y !== 32'h0) begin n_fail++; $display("FAIL reset_Y got %h want 0", bus.Y); end
    n_checks++; if (bus.op !== 4'h0) begin n_fail++; $display("FAIL reset_op got %h want 0", bus.op); end
    n_checks++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %0b want 0", bus.illegal_op); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_write_read();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_00A5;
    step();
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs = 5'd3; bus.rt = 5'd0; bus.alu_op = 4'd2;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.X !== 32'hA5) begin n_fail++; $display("FAIL wr_X got %h want 000000a5", bus.X); end
    n_checks++; if (bus.Y !== 32'h0) begin n_fail++; $display("FAIL wr_Y got %h want 0", bus.Y); end
    n_checks++; if (bus.op !== 4'd2) begin n_fail++; $display("FAIL wr_op got %h want 2", bus.op); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL consume_clear got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    bus.in_valid = 1'b1; bus.rs = 5'd5; bus.rt = 5'd0;
    step();
    n_checks++; if (bus.X !== 32'h1234) begin n_fail++; $display("FAIL bypass_X got %h want 00001234", bus.X); end
    n_checks++; if (bus.Y !== 32'h0) begin n_fail++; $display("FAIL bypass_Y got %h want 0", bus.Y); end
    bus.wb_addr = 5'd6; bus.wb_data = 32'h6666; bus.rs = 5'd0; bus.rt = 5'd6;
    step();
    n_checks++; if (bus.Y !== 32'h6666) begin n_fail++; $display("FAIL bypass_rt_Y got %h want 00006666", bus.Y); end
    n_checks++; if (bus.X !== 32'h0) begin n_fail++; $display("FAIL bypass_rt_X got %h want 0", bus.X); end
    bus.in_valid = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF;
    step();
    bus.wb_en = 1'b0; bus.in_valid = 1'b1; bus.rs = 5'd0; bus.rt = 5'd5;
    step();
    n_checks++; if (bus.X !== 32'h0) begin n_fail++; $display("FAIL zero_reg_X got %h want 0", bus.X); end
    n_checks++; if (bus.Y !== 32'h1234) begin n_fail++; $display("FAIL stored_r5_Y got %h want 00001234", bus.Y); end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF; bus.rs = 5'd0;
    step();
    n_checks++; if (bus.X !== 32'h0) begin n_fail++; $display("FAIL zero_no_bypass_X got %h want 0", bus.X); end
    idle_inputs();
    step();
  endtask

  task automatic test_immediate();
    idle_inputs();
    bus.in_valid = 1'b1; bus.alu_src = 1'b1; bus.rt = 5'd3; bus.imm = 16'h8001; bus.alu_op = 4'd6;
    step();
    n_checks++; if (bus.Y !== 32'hFFFF_8001) begin n_fail++; $display("FAIL imm_neg_Y got %h want ffff8001", bus.Y); end
    n_checks++; if (bus.op !== 4'd6) begin n_fail++; $display("FAIL imm_neg_op got %h want 6", bus.op); end
    bus.imm = 16'h7FFF; bus.alu_op = 4'd7;
    step();
    n_checks++; if (bus.Y !== 32'h0000_7FFF) begin n_fail++; $display("FAIL imm_pos_Y got %h want 00007fff", bus.Y); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_b2b_valid got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.op !== 4'd7) begin n_fail++; $display("FAIL imm_pos_op got %h want 7", bus.op); end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.rs = 5'd3; bus.rt = 5'd5; bus.alu_op = 4'd1;
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
    bus.rs = 5'd6; bus.alu_op = 4'd12;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %0b want 0", i, bus.in_ready); end
      n_checks++; if (bus.X !== 32'hA5 || bus.Y !== 32'h1234 || bus.op !== 4'd1 || bus.out_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d] got X=%h Y=%h op=%h v=%0b want X=a5 Y=1234 op=1 v=1", i, bus.X, bus.Y, bus.op, bus.out_valid); end
      step();
    end
    bus.wb_en = 1'b0; bus.out_ready = 1'b1; bus.rs = 5'd3; bus.rt = 5'd0; bus.alu_op = 4'd7;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.X !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_X got %h want deadbeef", bus.X); end
    n_checks++; if (bus.op !== 4'd7) begin n_fail++; $display("FAIL b2b_op got %h want 7", bus.op); end
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.X !== 32'hDEAD_BEEF || bus.Y !== 32'h0 || bus.op !== 4'd7)
      begin n_fail++; $display("FAIL idle_hold got v=%0b X=%h Y=%h op=%h want v=1 X=deadbeef Y=0 op=7", bus.out_valid, bus.X, bus.Y, bus.op); end
    idle_inputs();
    step();
  endtask

  task automatic test_illegal();
    idle_inputs();
    pulse_reset();
    bus.in_valid = 1'b1; bus.alu_op = 4'd4;
    step();
    n_checks++; if (bus.op !== 4'd4 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_xfer got op=%h v=%0b want op=4 v=1", bus.op, bus.out_valid); end
    n_checks++; if (bus.illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_set got %0b want 1", bus.illegal_op); end
    bus.alu_op = 4'd12;
    step();
    bus.in_valid = 1'b0;
    step();
    n_checks++; if (bus.illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %0b want 1", bus.illegal_op); end
  endtask

  task automatic test_legal_ops();
    logic [15:0] legal_tbl = 16'h90C7;
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      pulse_reset();
      bus.in_valid = 1'b1; bus.alu_op = 4'(i);
      step();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.illegal_op !== !legal_tbl[i] || bus.op !== 4'(i))
        begin n_fail++; $display("FAIL op_decode[%0d] got ill=%0b op=%h want ill=%0b", i, bus.illegal_op, bus.op, !legal_tbl[i]); end
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
    step();
    idle_inputs();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.rs = 5'd3; bus.alu_src = 1'b1; bus.imm = 16'h0001; bus.alu_op = 4'd4;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.X !== 32'h55 || bus.Y !== 32'h1 || bus.illegal_op !== 1'b1)
      begin n_fail++; $display("FAIL prestall got X=%h Y=%h ill=%0b want X=55 Y=1 ill=1", bus.X, bus.Y, bus.illegal_op); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.X !== 32'h0 || bus.Y !== 32'h0 || bus.illegal_op !== 1'b0 || bus.op !== 4'h0)
      begin n_fail++; $display("FAIL async_reset got v=%0b X=%h Y=%h ill=%0b op=%h want all 0", bus.out_valid, bus.X, bus.Y, bus.illegal_op, bus.op); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_in_ready got %0b want 1", bus.in_ready); end
    #1 rst_n = 1'b1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.rs = 5'd3; bus.rt = 5'd3;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.X !== 32'h0 || bus.Y !== 32'h0 || bus.out_valid !== 1'b1)
      begin n_fail++; $display("FAIL r3_after_reset got X=%h Y=%h v=%0b want X=0 Y=0 v=1", bus.X, bus.Y, bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_immediate();
    test_backpressure();
    test_hold();
    test_illegal();
    test_legal_ops();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand, register and write-back data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width (2^ADDR_W registers).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 in_valid  input  1  SHALL indicate that the decoded-instruction fields are valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a transfer this cycle.
REQ-007 rs  input  ADDR_W  SHALL be the source register index for X.
REQ-008 rt  input  ADDR_W  SHALL be the source register index for Y when alu_src=0.
REQ-009 imm  input  16  SHALL be the immediate field.
REQ-010 alu_src  input  1  SHALL select Y: 0 = register[rt], 1 = sign-extended imm.
REQ-011 alu_op  input  4  SHALL be the ALU operation code.
REQ-012 wb_en  input  1  SHALL enable the register write-back.
REQ-013 wb_addr  input  ADDR_W  SHALL be the write-back register index.
REQ-014 wb_data  input  DATA_W  SHALL be the write-back data (ALU result from downstream).
REQ-015 out_valid  output  1  SHALL indicate that X/Y/op hold a valid operand set for the ALU.
REQ-016 out_ready  input  1  SHALL indicate that the ALU stage consumes the operands this cycle.
REQ-017 X  output  DATA_W  SHALL be the registered first ALU operand.
REQ-018 Y  output  DATA_W  SHALL be the registered second ALU operand.
REQ-019 op  output  4  SHALL be the registered ALU operation code.
REQ-020 illegal_op  output  1  SHALL be the sticky flag for an unsupported op code.

Function
REQ-021 The register file SHALL contain 2^ADDR_W registers of DATA_W bits; register 0 SHALL always read 0, and writes to register 0 SHALL be ignored.
REQ-022 A write SHALL occur on every rising edge with wb_en=1, independent of the in/out handshakes.
REQ-023 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-024 Accept occurs when in_valid && in_ready; on accept, X, Y and op SHALL be loaded on that edge and out_valid SHALL be 1 on the next cycle. Latency is 1 cycle, with a throughput of 1 transfer per cycle.
REQ-025 Register reads SHALL be bypassed: if wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt) in the accept cycle, X (or Y) SHALL capture wb_data rather than the stored value.
REQ-026 When alu_src=1, Y SHALL equal {{(DATA_W-16){imm[15]}}, imm}, with rt ignored.
REQ-027 op SHALL capture alu_op unchanged.
REQ-028 When out_valid=1 and out_ready=1 with no accept, out_valid SHALL clear on the next edge.
REQ-029 Simultaneous consume and accept in the same cycle SHALL replace X/Y/op with no bubble, and out_valid SHALL stay 1.
REQ-030 While out_valid=1 and out_ready=0, X/Y/op SHALL remain stable. Later write-backs SHALL NOT update the held operands; hazard avoidance is upstream's duty.
REQ-031 Legal op codes SHALL be {0,1,2,6,7,12,15}. An accepted transfer with any other alu_op SHALL set illegal_op, which stays 1 until reset; that transfer SHALL still proceed normally.
REQ-032 When in_valid=0 and no consume occurs, the output state SHALL hold.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear all registers, out_valid, X, Y, op and illegal_op to 0.
REQ-034 in_ready SHALL read 1 during reset and after reset is released.
REQ-035 Reset asserted mid-transfer SHALL discard any pending output, and no transfer SHALL complete in that cycle.
REQ-036 Operation SHALL resume on the first rising edge after rst_n returns to 1.

Verification
REQ-037 Write-then-read: wb_en=1, wb_addr=3, wb_data=0x0000_00A5; next cycle accept rs=3, rt=0, alu_src=0, alu_op=2 -> next cycle out_valid=1, X=0xA5, Y=0, op=2.
REQ-038 Bypass and zero register: in one cycle wb_en=1, wb_addr=5, wb_data=0x1234 and accept rs=5, rt=0 -> X=0x1234, Y=0. Write wb_addr=0 with 0xFFFF, then read rs=0 -> X=0.
REQ-039 Immediate: accept alu_src=1, imm=0x8001 -> Y=0xFFFF_8001. Accept imm=0x7FFF -> Y=0x0000_7FFF.
REQ-040 Backpressure: hold out_ready=0 for 3 cycles after an accept -> in_ready=0 and X/Y/op stable, even with a write-back to rs. Raise out_ready together with in_valid=1 -> back-to-back transfer, out_valid stays 1.
REQ-041 Illegal op: accept alu_op=4 -> op=4, out_valid=1 and illegal_op=1, which persists through later legal ops until rst_n=0.
REQ-042 Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 asynchronously -> out_valid, X, Y and illegal_op are 0 immediately; register 3 reads 0 after release.
